bus_grant_encoder: RTL and testbench

BUS_GRANT_ENCODER -- requirements
Module: bus_grant_encoder

---
 rtl/bus_grant_encoder.sv | 167 ++++++++++++++++
 tb/tb_bus_grant_encoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_grant_encoder.sv
`default_nettype none
// ============================================================================
// Module      : bus_grant_encoder
// Description : Request-to-grant encoder with a two-state IDLE/GRANT FSM.
//               Arbitrates a request vector (lowest index wins by default),
//               issues a registered binary index plus its one-hot copy,
//               holds it until acknowledged or withdrawn, and keeps a
//               saturating count of grants issued from multi-hot requests.
//               Define BUS_GRANT_RR_EN to switch to round-robin arbitration
//               with a wrap-around search pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_grant_encoder #(
    parameter int N = 32,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [W-1:0] sel,
    output logic [N-1:0] grant,
    output logic         valid,
    output logic         mhot,
    output logic [7:0]   mhot_cnt
);

    localparam logic [W-1:0] c_sel_idle = {W{1'b1}};
    localparam logic [7:0]   c_cnt_max  = 8'hFF;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // Reject configurations the encoded index cannot represent
    generate
        if ((N < 2) || (N > 64) || ((2 ** W) < N)) begin : g_param_check
            $error("bus_grant_encoder: illegal N/W combination");
        end
    endgenerate

    state_t       r_state;
    logic [W-1:0] r_sel;
    logic [N-1:0] r_grant;
    logic         r_valid;
    logic         r_mhot;
    logic [7:0]   r_cnt;

    logic [N-1:0] w_vec;
    logic         w_any;
    logic         w_multi;
    logic         w_held;
    logic [W-1:0] w_pick;
    logic         w_issue;
    logic         w_drop;

    // Candidate vector: while granting, the current owner is excluded so an
    // acknowledged grant moves on to another requester
    always_comb begin
        w_vec   = (r_state == S_GRANT) ? (req & ~r_grant) : req;
        w_any   = |w_vec;
        w_multi = |(w_vec & (w_vec - N'(1)));
        w_held  = |(req & r_grant);
    end

`ifdef BUS_GRANT_RR_EN
    localparam logic [W:0]   c_n_ext = (W+1)'(N);
    localparam logic [W-1:0] c_last  = W'(N - 1);

    logic [W-1:0] r_ptr;
    logic [W:0]   w_pos;

    // Round-robin search starting at the pointer, wrapping past N-1;
    // iterating downwards lets the nearest hit overwrite farther ones
    always_comb begin
        w_pick = '0;
        w_pos  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = {1'b0, r_ptr} + (W+1)'(k);
            if (w_pos >= c_n_ext) begin
                w_pos = w_pos - c_n_ext;
            end
            if (w_vec[w_pos[W-1:0]]) begin
                w_pick = w_pos[W-1:0];
            end
        end
    end

    // Pointer advances to one past each newly granted index
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (w_pick == c_last) ? '0 : (w_pick + W'(1));
        end
    end
`else
    // Fixed priority: lowest set index wins (downward loop, last hit kept)
    always_comb begin
        w_pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_vec[k]) begin
                w_pick = W'(k);
            end
        end
    end
`endif

    // Decide whether the next edge issues a new grant or returns to idle;
    // ack is only honoured while a grant is live
    always_comb begin
        w_issue = 1'b0;
        w_drop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_issue = w_any;
            end
            S_GRANT: begin
                if (ack) begin
                    w_issue = w_any;
                    w_drop  = ~w_any;
                end else begin
                    w_drop  = ~w_held;
                end
            end
            default: begin
                w_drop = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_sel   <= c_sel_idle;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_mhot  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_issue) begin
            r_state <= S_GRANT;
            r_sel   <= w_pick;
            r_grant <= N'(1) << w_pick;
            r_valid <= 1'b1;
            r_mhot  <= w_multi;
            if (w_multi && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end else if (w_drop) begin
            r_state <= S_IDLE;
            r_sel   <= c_sel_idle;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_mhot  <= 1'b0;
        end
    end

    assign sel      = r_sel;
    assign grant    = r_grant;
    assign valid    = r_valid;
    assign mhot     = r_mhot;
    assign mhot_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bus_grant_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_grant_encoder
// Description : Self-checking bench for bus_grant_encoder: directed vector
//               table, multi-cycle corner sequences (saturation, async reset,
//               round-robin wrap when BUS_GRANT_RR_EN is defined) and random
//               stimulus against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_grant_encoder;

    localparam int N = 32;
    localparam int W = 5;
    localparam int SEL_IDLE = (1 << W) - 1;

    logic         clk;
    logic         clr;
    logic [N-1:0] req;
    logic         ack;
    logic [W-1:0] sel;
    logic [N-1:0] grant;
    logic         valid;
    logic         mhot;
    logic [7:0]   mhot_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_valid;
    int m_sel;
    int m_mhot;
    int m_cnt;
    int m_ptr;

    bus_grant_encoder #(.N(N), .W(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .req      (req),
        .ack      (ack),
        .sel      (sel),
        .grant    (grant),
        .valid    (valid),
        .mhot     (mhot),
        .mhot_cnt (mhot_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot_of(input int v, input int s);
        logic [N-1:0] g;
        g = '0;
        if (v != 0) g[s] = 1'b1;
        return g;
    endfunction

    function automatic int first_set(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_sel   = SEL_IDLE;
        m_mhot  = 0;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    task automatic model_idle();
        m_valid = 0;
        m_sel   = SEL_IDLE;
        m_mhot  = 0;
    endtask

    // One clock of the behavioural model with the inputs sampled at that edge
    task automatic model_clock(input logic [N-1:0] r, input logic a);
        logic [N-1:0] cand;
        bit arb;
        int idx;
        int start;
        cand = r;
        arb  = 1'b0;
        if (m_valid == 0) begin
            arb = 1'b1;
        end else if (a) begin
            cand[m_sel] = 1'b0;
            arb = 1'b1;
        end else if (!r[m_sel]) begin
            model_idle();
        end
        if (arb) begin
`ifdef BUS_GRANT_RR_EN
            start = m_ptr;
`else
            start = 0;
`endif
            idx = first_set(cand, start);
            if (idx < 0) begin
                model_idle();
            end else begin
                m_valid = 1;
                m_sel   = idx;
                m_mhot  = ($countones(cand) >= 2) ? 1 : 0;
                if (m_mhot != 0 && m_cnt < 255) m_cnt++;
                m_ptr   = (idx + 1) % N;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, valid, m_valid);
        chk({tag, "_sel"}, sel, m_sel);
        chk({tag, "_grant"}, grant, onehot_of(m_valid, m_sel));
        chk({tag, "_mhot"}, mhot, m_mhot);
        chk({tag, "_cnt"}, mhot_cnt, m_cnt);
    endtask

    // Apply inputs, clock once, advance the model, settle past the edge
    task automatic step(input logic [N-1:0] r, input logic a);
        req = r;
        ack = a;
        @(posedge clk);
        model_clock(r, a);
        #1;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         ack;
        int           valid;
        int           sel;
        int           mhot;
        int           cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [N-1:0] prev;
        int rr_exp[8];

        // Fixed-priority directed sequence, applied from reset
        tbl[0]  = '{32'h0000_1000, 1'b0, 1, 12, 0, 0};
        tbl[1]  = '{32'h0000_1000, 1'b1, 0, SEL_IDLE, 0, 0};
        tbl[2]  = '{32'h8000_0081, 1'b0, 1, 0, 1, 1};
        tbl[3]  = '{32'h8000_0081, 1'b1, 1, 7, 1, 2};
        tbl[4]  = '{32'h8000_0081, 1'b1, 1, 0, 1, 3};
        tbl[5]  = '{32'h0000_0008, 1'b1, 1, 3, 0, 3};
        tbl[6]  = '{32'h0000_0008, 1'b0, 1, 3, 0, 3};
        tbl[7]  = '{32'h0000_0000, 1'b0, 0, SEL_IDLE, 0, 3};
        tbl[8]  = '{32'h0000_0000, 1'b1, 0, SEL_IDLE, 0, 3};
        tbl[9]  = '{32'h0000_0006, 1'b1, 1, 1, 1, 4};
        tbl[10] = '{32'h0000_0004, 1'b0, 0, SEL_IDLE, 0, 4};
        tbl[11] = '{32'h0000_0004, 1'b0, 1, 2, 0, 4};
        tbl[12] = '{32'hFFFF_0004, 1'b0, 1, 2, 0, 4};

        rr_exp = '{0, 2, 0, 2, 31, 0, 31, 0};

        clr = 1'b1;
        req = '0;
        ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", valid, 0);
        chk("reset_sel", sel, SEL_IDLE);
        chk("reset_grant", grant, 0);
        chk("reset_mhot", mhot, 0);
        chk("reset_cnt", mhot_cnt, 0);
        clr = 1'b0;

        // No grant without a request after reset release
        step('0, 1'b0);
        check_model("post_reset_idle");

`ifdef BUS_GRANT_RR_EN
        // Round-robin alternation and wrap from 31 back to 0
        for (int i = 0; i < 8; i++) begin
            step((i < 4) ? 32'h0000_0005 : 32'h8000_0001, 1'b1);
            chk($sformatf("rr%0d_sel", i), sel, rr_exp[i]);
            chk($sformatf("rr%0d_valid", i), valid, 1);
            check_model($sformatf("rr%0d", i));
        end
`else
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].req, tbl[i].ack);
            chk($sformatf("vec%0d_valid", i), valid, tbl[i].valid);
            chk($sformatf("vec%0d_sel", i), sel, tbl[i].sel);
            chk($sformatf("vec%0d_grant", i), grant, onehot_of(tbl[i].valid, tbl[i].sel));
            chk($sformatf("vec%0d_mhot", i), mhot, tbl[i].mhot);
            chk($sformatf("vec%0d_cnt", i), mhot_cnt, tbl[i].cnt);
        end
`endif

        // Saturation: every grant from req=0x7 with ack is multi-hot
        for (int i = 0; i < 300; i++) begin
            step(32'h0000_0007, 1'b1);
        end
        chk("sat_cnt", mhot_cnt, 255);
        check_model("sat");
        for (int i = 0; i < 5; i++) begin
            step(32'h0000_0007, 1'b1);
        end
        chk("sat_hold_cnt", mhot_cnt, 255);
        chk("sat_hold_mhot", mhot, 1);

        // Asynchronous reset in the middle of a live grant on index 9
        step('0, 1'b0);
        step(32'h0000_0200, 1'b0);
        chk("pre_rst_sel", sel, 9);
        chk("pre_rst_valid", valid, 1);
        #3;
        clr = 1'b1;
        #1;
        chk("async_rst_valid", valid, 0);
        chk("async_rst_sel", sel, SEL_IDLE);
        chk("async_rst_grant", grant, 0);
        chk("async_rst_cnt", mhot_cnt, 0);
        model_reset();
        #2;
        clr = 1'b0;
        step('0, 1'b0);
        check_model("after_rst_idle");
        step(32'h0000_0200, 1'b0);
        chk("after_rst_sel", sel, 9);
        check_model("after_rst_grant");

        // Random traffic against the reference model
        prev = '0;
        for (int i = 0; i < 1500; i++) begin
            logic [N-1:0] r;
            case ($urandom_range(0, 3))
                0:       r = '0;
                1:       r = N'(1) << $urandom_range(0, N - 1);
                2:       r = N'($urandom) & N'($urandom) & N'($urandom);
                default: r = prev;
            endcase
            prev = r;
            step(r, 1'($urandom_range(0, 1)));
            check_model($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
